// File: rtl/cpu_trace_defs.sv
// Shared definitions for the CPU trace buffer.
// State encodings and the stored entry layout.
package cpu_trace_defs;

  localparam int ENTRY_W = 65;

  typedef enum logic [1:0] {
    TRACE_IDLE  = 2'd0,
    TRACE_ARMED = 2'd1,
    TRACE_POST  = 2'd2,
    TRACE_DONE  = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic        is_trig;
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: register array, synchronous write,
// asynchronous read so readout is visible in the same cycle.
module trace_ram
  import cpu_trace_defs::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Capture one entry per write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// PC-triggered circular trace capture with oldest-first
// readout; FSM, pointers and counters live here.
module cpu_trace_buffer
  import cpu_trace_defs::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int POST_TRIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic              arm,
  input  logic              trigEnable,
  input  logic [31:0]       trigPc,
  input  logic              rdEn,
  output logic              rdValid,
  output logic [31:0]       rdPc,
  output logic [31:0]       rdInstr,
  output logic              rdIsTrig,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              overflowed
);

  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

  trace_state_e      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              we;
  logic              trig_hit;
  trace_entry_t      wr_entry;
  trace_entry_t      rd_entry;
  logic [ENTRY_W-1:0] rd_raw;

  assign trig_hit = trigEnable && (pc == trigPc);

  // Next-state: arm wins, then capture/readout per state.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    wr_entry   = '{is_trig: 1'b0, pc: pc, instr: instruction};
    if (arm) begin
      state_d    = TRACE_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      post_cnt_d = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        TRACE_IDLE: begin
        end
        TRACE_ARMED: begin
          we = 1'b1;
          wr_entry.is_trig = trig_hit;
          if (trig_hit) begin
            if (POST_TRIG == 0) begin
              state_d = TRACE_DONE;
            end else begin
              state_d    = TRACE_POST;
              post_cnt_d = POST_INIT;
            end
          end
        end
        TRACE_POST: begin
          we = 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == ADDR_W'(1)) begin
            state_d = TRACE_DONE;
          end
        end
        TRACE_DONE: begin
          if (rdEn && rdValid) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
      endcase
      if (we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        // Point readout at the oldest retained entry.
        if (state_d == TRACE_DONE) begin
          rd_ptr_d = wr_ptr_d - count_d[ADDR_W-1:0];
        end
      end
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TRACE_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_raw)
  );

  assign rd_entry   = trace_entry_t'(rd_raw);
  assign rdValid    = (state_q == TRACE_DONE) && (count_q != '0);
  assign rdPc       = rdValid ? rd_entry.pc : '0;
  assign rdInstr    = rdValid ? rd_entry.instr : '0;
  assign rdIsTrig   = rdValid ? rd_entry.is_trig : 1'b0;
  assign state      = state_q;
  assign count      = count_q;
  assign overflowed = ovf_q;

endmodule
